nonce_dispatcher: RTL

Producer side of the hash-check interface. Walks a nonce range and drives `nonce` and the round counter `count` into the SHA core and the hash checker. After each hash it samples the checker's 33-bit `{flag, nonce}` result. It reports either the first winning nonce or range exhaustion upstream over a valid/ready handshake.

---
 rtl/nonce_dispatcher.sv | 72 +++++++
 1 files changed

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: walks a nonce range through the hash core and reports the first hit or exhaustion.
module nonce_dispatcher #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] nonce_base,
    input  logic [31:0] nonce_limit,
    input  logic [32:0] flag_plus_nonce,
    output logic [31:0] nonce,
    output logic [5:0]  count,
    output logic        busy,
    output logic        result_valid,
    output logic        result_found,
    output logic [31:0] result_nonce,
    input  logic        result_ready,
    output logic [31:0] hash_count
);
    typedef enum logic [1:0] {IDLE, RUN, CHECK, REPORT} state_t;
    state_t state, state_next;
    logic [31:0] limit;
    logic last;
    assign last = count == 6'(ROUNDS - 1);
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (start && !stop) ? RUN : IDLE;
            RUN:     state_next = stop ? IDLE : last ? CHECK : RUN;
            CHECK:   state_next = stop ? IDLE : (flag_plus_nonce[32] || nonce == limit) ? REPORT : RUN;
            REPORT:  state_next = result_ready ? IDLE : REPORT;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            limit        <= '0;
            nonce        <= '0;
            count        <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_found <= 1'b0;
            result_nonce <= '0;
            hash_count   <= '0;
        end else begin
            state        <= state_next;
            busy         <= state_next != IDLE;
            result_valid <= state_next == REPORT;
            count        <= (state == RUN && state_next == RUN) ? count + 6'd1 : 6'd0;
            if (state == IDLE && state_next == RUN) begin
                limit      <= nonce_limit;
                nonce      <= nonce_base;
                hash_count <= '0;
            end
            // stop in CHECK discards the outcome and leaves hash_count frozen
            if (state == CHECK && !stop) begin
                hash_count <= hash_count + 32'd1;
                if (flag_plus_nonce[32]) begin
                    result_found <= 1'b1;
                    result_nonce <= flag_plus_nonce[31:0];
                end else if (nonce == limit) begin
                    result_found <= 1'b0;
                    result_nonce <= limit;
                end else begin
                    nonce <= nonce + 32'd1;
                end
            end
        end
    end
endmodule
